// File: rtl/inv_mix_columns.sv
// AES InvMixColumns: one 128-bit state per handshake, COLS_PER_CYCLE columns per BUSY cycle.
// Define INV_MIX_FWD_EN to add fwd_mode, which selects the forward MixColumns matrix at accept.
module inv_mix_columns #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef INV_MIX_FWD_EN
  input  logic         fwd_mode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("inv_mix_columns: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam int         LAST = 4 - COLS_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q;
  logic [1:0]   col_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;
  logic [127:0] res_q;
  logic [127:0] work_q;
  logic [127:0] work_d;
`ifdef INV_MIX_FWD_EN
  logic         fwd_q;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] a);
    logic [7:0]  x1 [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] b;
    b = '0;
    for (int r = 0; r < 4; r++) begin
      x1[r] = a[31-8*r -: 8];
      x2[r] = xtime(x1[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
    end
    // 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3)
    for (int r = 0; r < 4; r++) begin
      b[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                     ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ x1[(r+1)%4])
                     ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ x1[(r+2)%4])
                     ^ (x8[(r+3)%4] ^ x1[(r+3)%4]);
    end
    return b;
  endfunction

`ifdef INV_MIX_FWD_EN
  function automatic logic [31:0] fwd_col(input logic [31:0] a);
    logic [7:0]  x1 [4];
    logic [7:0]  x2 [4];
    logic [31:0] b;
    b = '0;
    for (int r = 0; r < 4; r++) begin
      x1[r] = a[31-8*r -: 8];
      x2[r] = xtime(x1[r]);
    end
    for (int r = 0; r < 4; r++) begin
      b[31-8*r -: 8] = x2[r] ^ x2[(r+1)%4] ^ x1[(r+1)%4] ^ x1[(r+2)%4] ^ x1[(r+3)%4];
    end
    return b;
  endfunction
`endif

  // Columns are independent, so each one is transformed in place in the work register.
  always_comb begin
    work_d = work_q;
    for (int c = 0; c < 4; c++) begin
      if (c >= int'(col_q) && c < int'(col_q) + COLS_PER_CYCLE) begin
`ifdef INV_MIX_FWD_EN
        work_d[127-32*c -: 32] = fwd_q ? fwd_col(work_q[127-32*c -: 32])
                                       : inv_col(work_q[127-32*c -: 32]);
`else
        work_d[127-32*c -: 32] = inv_col(work_q[127-32*c -: 32]);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      work_q <= in_state;
`ifdef INV_MIX_FWD_EN
      fwd_q  <= fwd_mode;
`endif
    end else if (state_q == BUSY) begin
      work_q <= work_d;
    end
  end

  // The result register is only loaded on entry to DONE, so out_state holds between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      res_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= BUSY;
            col_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        BUSY: begin
          col_q <= col_q + STEP;
          if (int'(col_q) == LAST) begin
            state_q     <= DONE;
            col_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            res_q       <= work_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          col_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = res_q;

endmodule

// File: tb/tb_inv_mix_columns.sv
// Self-checking bench for inv_mix_columns: vector table, handshake corner cases, random vs GF model.
module tb_inv_mix_columns;

  localparam int COLS = 1;
  localparam int EXP_LAT = 4 / COLS + 1;

  localparam logic [127:0] VA_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] VA_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VB_IN  = 128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff;
  localparam logic [127:0] VB_OUT = 128'h2d26314c_d4d4d4d5_00000000_ffffffff;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
`ifdef INV_MIX_FWD_EN
  logic         fwd_mode;
`endif

  int total = 0;
  int bad   = 0;

  inv_mix_columns #(.COLS_PER_CYCLE(COLS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
`ifdef INV_MIX_FWD_EN
    .fwd_mode  (fwd_mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] din;
    logic         fwd;
    logic [127:0] dout;
  } vec_t;

  // Carry-less product then polynomial reduction by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model_mix(input logic [127:0] s, input logic fm);
    logic [7:0]   coef [4];
    logic [7:0]   a [4];
    logic [7:0]   b;
    logic [127:0] r;
    r = '0;
    if (fm) coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    else    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127-8*(4*c+k) -: 8];
      for (int row = 0; row < 4; row++) begin
        b = '0;
        for (int j = 0; j < 4; j++) b = b ^ gmul(coef[(j - row + 4) % 4], a[j]);
        r[127-8*(4*c+row) -: 8] = b;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after a clock edge with the DUT idle; returns result and cycles from accept to out_valid.
  task automatic run_one(input logic [127:0] s, output logic [127:0] res, output int lat);
    int n;
    chk("ready_before_accept", 128'(in_ready), 128'd1);
    in_state = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = ~s;
    chk("busy_flag", 128'(busy), 128'd1);
    chk("ready_in_busy", 128'(in_ready), 128'd0);
    lat = 1;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      lat++;
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 128'd0, 128'd1);
    res = out_state;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ready_after_retire", 128'(in_ready), 128'd1);
    chk("valid_after_retire", 128'(out_valid), 128'd0);
  endtask

  initial begin
    vec_t         tbl[$];
    logic [127:0] res;
    logic [127:0] got[$];
    logic [127:0] s;
    logic [127:0] y;
    logic         fm;
    logic         acc;
    int           lat;
    int           fi;
    int           n;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_state  = '0;
`ifdef INV_MIX_FWD_EN
    fwd_mode  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_out_state", out_state, 128'd0);

    for (int i = 0; i < 10; i++) begin
      in_state = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    chk("idle_in_ready", 128'(in_ready), 128'd1);
    chk("idle_out_valid", 128'(out_valid), 128'd0);
    chk("idle_busy", 128'(busy), 128'd0);
    chk("idle_out_state", out_state, 128'd0);

    tbl.push_back('{VA_IN, 1'b0, VA_OUT});
    tbl.push_back('{VB_IN, 1'b0, VB_OUT});
    tbl.push_back('{128'h0, 1'b0, 128'h0});
    tbl.push_back('{{16{8'hff}}, 1'b0, {16{8'hff}}});
    tbl.push_back('{{16{8'h01}}, 1'b0, {16{8'h01}}});
`ifdef INV_MIX_FWD_EN
    tbl.push_back('{VA_OUT, 1'b1, VA_IN});
    tbl.push_back('{VB_OUT, 1'b1, VB_IN});
`endif
    foreach (tbl[i]) begin
`ifdef INV_MIX_FWD_EN
      fwd_mode = tbl[i].fwd;
`endif
      run_one(tbl[i].din, res, lat);
      chk($sformatf("table_result_%0d", i), res, tbl[i].dout);
      chk($sformatf("table_latency_%0d", i), 128'(lat), 128'(EXP_LAT));
      retire();
    end
`ifdef INV_MIX_FWD_EN
    fwd_mode = 1'b0;
`endif

    // Backpressure: result held while a new request is presented and must be ignored.
    run_one(VA_IN, res, lat);
    chk("bp_first_result", res, VA_OUT);
    in_state = VB_IN;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_out_state", out_state, VA_OUT);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    retire();
    chk("bp_state_after_retire", out_state, VA_OUT);

    // Back-to-back with in_valid and out_ready held high.
    got.delete();
    fi = 0;
    n = 0;
    in_state = VA_IN;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (got.size() < 2 && n < 100) begin
      acc = in_valid && in_ready;
      if (out_valid && out_ready) got.push_back(out_state);
      @(posedge clk); #1;
      n++;
      if (acc) begin
        fi++;
        if (fi < 2) in_state = VB_IN;
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", 128'(got.size()), 128'd2);
    if (got.size() == 2) begin
      chk("b2b_first", got[0], VA_OUT);
      chk("b2b_second", got[1], VB_OUT);
    end
    @(posedge clk); #1;
    chk("b2b_hold_last", out_state, VB_OUT);

    // Reset on the second BUSY cycle discards the in-flight state.
    in_state = VA_IN;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_out_state", out_state, 128'd0);
    run_one(VA_IN, res, lat);
    chk("midrst_result", res, VA_OUT);
    chk("midrst_latency", 128'(lat), 128'(EXP_LAT));
    retire();

    // Random states against the reference model.
    for (int i = 0; i < 24; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      fm = 1'b0;
`ifdef INV_MIX_FWD_EN
      fm = 1'($urandom_range(0, 1));
      fwd_mode = fm;
`endif
      run_one(s, res, lat);
      chk($sformatf("rand_result_%0d", i), res, model_mix(s, fm));
      retire();
    end

`ifdef INV_MIX_FWD_EN
    // Forward then inverse returns the original state.
    for (int i = 0; i < 4; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      fwd_mode = 1'b1;
      run_one(s, y, lat);
      retire();
      fwd_mode = 1'b0;
      run_one(y, res, lat);
      chk($sformatf("roundtrip_%0d", i), res, s);
      retire();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
